// File: rtl/brightness_slew_if.sv
// brightness_slew_if: raw brightness sample valid/ready channel.
interface brightness_slew_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/brightness_slew.sv
// brightness_slew: box-car average, clamp and slew-limit the dimmer level.
// Optional MOTION_HOLD_EN adds a motion-triggered full-brightness hold.
module brightness_slew #(
    parameter int AVG_LOG2   = 2,
    parameter int TICK_DIV   = 500_000,
    parameter int STEP       = 8,
    parameter int MAX_LEVEL  = 510,
    parameter int HOLD_TICKS = 64
) (
    input  logic             sys_clk,
    input  logic             rst,
    brightness_slew_if.slave s_if,
`ifdef MOTION_HOLD_EN
    input  logic             motion,
`endif
    output logic [15:0]      brightness,
    output logic [15:0]      target,
    output logic             at_max,
    output logic             at_min
);
    localparam int NSMP = 1 << AVG_LOG2;
    localparam int CW   = AVG_LOG2 + 1;
    localparam int AW   = 16 + AVG_LOG2;
    localparam int TW   = $clog2(TICK_DIV);
    localparam logic [15:0] MAXL = 16'(MAX_LEVEL);
    localparam logic [15:0] STP  = 16'(STEP);

    typedef enum logic {S_ACCEPT, S_AVERAGE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tick;
    logic [15:0]   r_bright;
    logic [15:0]   r_target;
    logic          r_at_max;
    logic          r_at_min;
    logic          w_ready;
    logic          w_hs;
    logic          w_tick;
    logic [CW-1:0] w_cnt_inc;
    logic [15:0]   w_avg;
    logic [15:0]   w_gap;
    logic [15:0]   w_slew;
    logic [15:0]   w_bright_nxt;

    assign w_hs      = s_if.sample_valid & (r_state == S_ACCEPT);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_tick    = (r_tick == TW'(TICK_DIV - 1));
    assign w_avg     = 16'(r_acc >> AVG_LOG2);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_state <= S_ACCEPT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        unique case (r_state)
            S_ACCEPT: begin
                w_ready = 1'b1;
                if (w_hs && (w_cnt_inc == CW'(NSMP)))
                    w_state_nxt = S_AVERAGE;
            end
            S_AVERAGE: w_state_nxt = S_ACCEPT;
        endcase
    end

    // Compare before subtracting so the unsigned gap never wraps.
    always_comb begin
        w_gap  = '0;
        w_slew = r_bright;
        if (r_bright < r_target) begin
            w_gap  = r_target - r_bright;
            w_slew = (w_gap > STP) ? r_bright + STP : r_target;
        end else if (r_bright > r_target) begin
            w_gap  = r_bright - r_target;
            w_slew = (w_gap > STP) ? r_bright - STP : r_target;
        end
    end

`ifdef MOTION_HOLD_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    logic          r_motion_d;
    logic [HW-1:0] r_hold;
    logic          w_motion_edge;

    assign w_motion_edge = motion & ~r_motion_d;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_motion_d <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_motion_d <= motion;
            if (w_motion_edge)
                r_hold <= HW'(HOLD_TICKS);
            else if ((r_hold != '0) && w_tick)
                r_hold <= r_hold - 1'b1;
        end
    end

    always_comb begin
        w_bright_nxt = w_tick ? w_slew : r_bright;
        if (w_motion_edge)
            w_bright_nxt = MAXL;
        else if (r_hold != '0)
            w_bright_nxt = r_bright;
    end
`else
    always_comb begin
        w_bright_nxt = w_tick ? w_slew : r_bright;
    end
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_tick   <= '0;
            r_bright <= '0;
            r_target <= '0;
            r_at_max <= 1'b0;
            r_at_min <= 1'b1;
        end else begin
            r_tick <= w_tick ? '0 : r_tick + 1'b1;
            if (r_state == S_AVERAGE) begin
                r_target <= (w_avg > MAXL) ? MAXL : w_avg;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (w_hs) begin
                r_acc <= r_acc + AW'(s_if.sample_in);
                r_cnt <= w_cnt_inc;
            end
            r_bright <= w_bright_nxt;
            r_at_max <= (w_bright_nxt == MAXL);
            r_at_min <= (w_bright_nxt == 16'd0);
        end
    end

    assign s_if.sample_ready = w_ready;
    assign brightness        = r_bright;
    assign target            = r_target;
    assign at_max            = r_at_max;
    assign at_min            = r_at_min;
endmodule

// File: tb/tb_brightness_slew.sv
// tb_brightness_slew: random samples vs. a behavioural averaging/slew model,
// with a target scoreboard popped whenever the block reports an average.
module tb_brightness_slew;
    localparam int TD = 4;
    localparam int ST = 8;
    localparam int AL = 2;
    localparam int ML = 510;
    localparam int HT = 64;
    localparam int NS = 1 << AL;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] brightness;
    logic [15:0] target;
    logic        at_max;
    logic        at_min;
    logic        motion = 1'b0;

    brightness_slew_if bus ();

    always #5 sys_clk = ~sys_clk;

    brightness_slew #(
        .AVG_LOG2(AL), .TICK_DIV(TD), .STEP(ST),
        .MAX_LEVEL(ML), .HOLD_TICKS(HT)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .s_if(bus.slave),
`ifdef MOTION_HOLD_EN
        .motion(motion),
`endif
        .brightness(brightness),
        .target(target),
        .at_max(at_max),
        .at_min(at_min)
    );

    int vectors = 0;
    int errors = 0;

    // Behavioural model state
    int m_sum, m_n, m_target, m_bright, m_cyc, m_hold, m_t0;
    bit m_pend, m_tick, m_edge, m_mot_d;
    int exp_q[$];
    bit chk_tgt = 0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            m_sum = 0; m_n = 0; m_pend = 0; m_target = 0;
            m_bright = 0; m_cyc = 0; m_hold = 0; m_mot_d = 0;
            exp_q.delete();
        end else begin
            m_tick = ((m_cyc % TD) == TD - 1);
            m_t0 = m_target;
            m_edge = 0;
`ifdef MOTION_HOLD_EN
            m_edge = motion && !m_mot_d;
            m_mot_d = motion;
`endif
            if (m_edge) begin
                m_bright = ML;
                m_hold = HT;
            end else if (m_hold > 0) begin
                if (m_tick) m_hold--;
            end else if (m_tick) begin
                if (m_bright < m_t0) m_bright += imin(ST, m_t0 - m_bright);
                else if (m_bright > m_t0) m_bright -= imin(ST, m_bright - m_t0);
            end
            if (m_pend) begin
                m_target = imin(m_sum / NS, ML);
                m_sum = 0; m_n = 0; m_pend = 0;
            end else if (bus.sample_valid) begin
                m_sum += int'(bus.sample_in);
                m_n++;
                if (m_n == NS) begin
                    m_pend = 1;
                    exp_q.push_back(imin(m_sum / NS, ML));
                end
            end
            m_cyc++;
        end
    end

    // Monitor: every cycle vs. the model, target popped after an average cycle.
    always @(negedge sys_clk) begin
        if (rst) begin
            chk("rst_brightness", brightness, 0);
            chk("rst_target", target, 0);
            chk("rst_at_min", at_min, 1);
            chk("rst_at_max", at_max, 0);
            chk("rst_ready", bus.sample_ready, 1);
            chk_tgt = 0;
        end else begin
            chk("brightness", brightness, m_bright);
            chk("at_max", at_max, (m_bright == ML));
            chk("at_min", at_min, (m_bright == 0));
            chk("sample_ready", bus.sample_ready, !m_pend);
            if (chk_tgt) begin
                chk_tgt = 0;
                if (exp_q.size() == 0) begin
                    chk("target_q_empty", 1, 0);
                end else begin
                    chk("target", target, exp_q.pop_front());
                end
            end
            if (!bus.sample_ready) chk_tgt = 1;
        end
    end

    task automatic send(input int v);
        int k;
        bus.sample_in = 16'(v);
        bus.sample_valid = 1'b1;
        k = 0;
        while (!bus.sample_ready && k < 10) begin
            @(negedge sys_clk);
            k++;
        end
        if (k >= 10) chk("ready_timeout", 0, 1);
        @(negedge sys_clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic group4(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        bus.sample_in = '0;
        bus.sample_valid = 1'b0;
        idle(3);
        #2 rst = 1'b0;
        idle(100);

        group4(100, 100, 100, 104);
        idle(80);
        chk("target_101", target, 101);
        chk("bright_101", brightness, 101);

        group4(1000, 1000, 1000, 1000);
        idle(300);
        chk("ramp_at_max", at_max, 1);
        group4(0, 0, 0, 0);
        idle(300);
        chk("ramp_at_min", at_min, 1);

        send(200); send(220);
        idle(50);
        send(240); send(260);
        idle(150);
        chk("stall_target", target, 230);

        group4(0, 0, 0, 0);
        idle(200);
        group4(1000, 1000, 1000, 1000);
        begin
            int k = 0;
            while (brightness != 16'd200 && k < 1000) begin
                @(negedge sys_clk);
                k++;
            end
        end
        chk("reach_200", brightness, 200);
        send(50); send(60);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bright", brightness, 0);
        chk("async_rst_at_min", at_min, 1);
        chk("async_rst_ready", bus.sample_ready, 1);
        idle(2);
        #2 rst = 1'b0;
        group4(40, 40, 40, 40);
        idle(30);
        chk("discard_partial", target, 40);

        for (int g = 0; g < 20; g++) begin
            for (int s = 0; s < NS; s++) begin
                send($urandom_range(0, 1200));
                idle($urandom_range(0, 3));
            end
            idle($urandom_range(0, 200));
        end
        idle(300);

`ifdef MOTION_HOLD_EN
        group4(100, 100, 100, 100);
        idle(300);
        chk("pre_motion", brightness, 100);
        motion = 1'b1;
        @(negedge sys_clk);
        chk("motion_max", brightness, ML);
        motion = 1'b0;
        idle(HT * TD - 8);
        chk("hold_max", brightness, ML);
        idle(400);
        chk("hold_release", brightness, 100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
